// File: rtl/neuron_acc_nbit.sv
// neuron_acc_nbit
// Sequential signed multiply-accumulate for one neuron pre-activation sum.
// K (x, w) pairs are accepted one per beat on a valid/ready stream. The block
// accumulates them at full precision, applies an arithmetic right shift of
// FRAC bits and saturates the result to N bits. The result is then held on a
// valid/ready output until it is consumed.
//
// Parameters:
//   N    operand / result width (two's complement)
//   K    pairs per sum (K >= 1)
//   FRAC arithmetic right shift applied before saturation (0 <= FRAC < 2N)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   an (x, w) pair is presented
//   in_ready   a pair is accepted this cycle (state only; low while rst is high)
//   x, w       signed operands
//   out_valid  o holds a completed sum
//   out_ready  downstream consumes o
//   o          saturated, shifted sum
module neuron_acc_nbit #(
  parameter int N    = 8,
  parameter int K    = 4,
  parameter int FRAC = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] x,
  input  logic signed [N-1:0] w,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] o
);

  // The accumulator has clog2(K) guard bits, so a sum of K full-scale
  // products can never overflow it.
  localparam int ACCW = 2*N + $clog2(K);
  localparam int CW   = (K > 1) ? $clog2(K) : 1;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_OUT   = 1'b1;

  // Saturation bounds, expressed at accumulator width
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-N+1){1'b1}}, {(N-1){1'b0}}};

  logic [0:0]             state_reg, state_next;
  logic signed [ACCW-1:0] acc_reg, acc_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic signed [N-1:0]    o_reg, o_next;

  logic signed [2*N-1:0]  prod;
  logic signed [ACCW-1:0] sum;
  logic signed [ACCW-1:0] shifted;
  logic signed [N-1:0]    sat_val;
  logic                   accept;
  logic                   last_beat;

  // Both operands are sign-extended to 2N before multiplying so the product
  // is exact.
  assign prod    = (2*N)'(x) * (2*N)'(w);
  assign sum     = acc_reg + ACCW'(prod);
  // Arithmetic shift: truncates toward minus infinity, no rounding
  assign shifted = sum >>> FRAC;

  always_comb begin
    sat_val = shifted[N-1:0];
    if (shifted > MAXV) begin
      sat_val = {1'b0, {(N-1){1'b1}}};
    end else if (shifted < MINV) begin
      sat_val = {1'b1, {(N-1){1'b0}}};
    end
  end

  // in_ready is gated by rst so that nothing looks acceptable during reset
  assign in_ready  = (state_reg == ST_ACCUM) && !rst;
  assign out_valid = (state_reg == ST_OUT);
  assign o         = o_reg;

  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt_reg == CW'(K-1));

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    o_next     = o_reg;
    case (state_reg)
      ST_ACCUM: begin
        if (accept) begin
          if (last_beat) begin
            // The final product is folded in combinationally, so the
            // accumulator is already clear for the next sum.
            o_next     = sat_val;
            acc_next   = '0;
            cnt_next   = '0;
            state_next = ST_OUT;
          end else begin
            acc_next = sum;
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_next = ST_ACCUM;
        end
      end
      default: begin
        state_next = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_ACCUM;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      o_reg     <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      o_reg     <= o_next;
    end
  end

endmodule

// File: tb/tb_neuron_acc_nbit.sv
// tb_neuron_acc_nbit
// Self-checking bench for neuron_acc_nbit. Two instances (FRAC=0 and FRAC=4)
// share one input stream. A transaction-level model keeps the accepted
// products in a queue and forms each sum arithmetically once K are present.
// Handshake outputs and o are compared every cycle, and the directed cases
// also check fixed expected constants.
module tb_neuron_acc_nbit;

  localparam int N = 8;
  localparam int K = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [N-1:0] x = '0;
  logic signed [N-1:0] w = '0;

  logic       in_ready, out_valid;
  logic [7:0] o;
  logic       in_ready4, out_valid4;
  logic [7:0] o4;

  always #5 clk = ~clk;

  neuron_acc_nbit #(.N(N), .K(K), .FRAC(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .w(w), .out_valid(out_valid), .out_ready(out_ready), .o(o)
  );

  neuron_acc_nbit #(.N(N), .K(K), .FRAC(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .x(x), .w(w), .out_valid(out_valid4), .out_ready(out_ready), .o(o4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint     prods[$];
  bit         pending = 0;
  logic [7:0] exp0 = '0;
  logic [7:0] exp4 = '0;
  int         cyc = 0;
  int         nsum = 0;
  bit         prev_ov = 0;
  int         rise_cyc[$];
  int         rdy_mode = 1;   // 0: out_ready low, 1: high, 2: random

  function automatic logic [7:0] sat8(input longint v);
    longint t;
    t = v;
    if (v > 127)  t = 127;
    if (v < -128) t = -128;
    return t[7:0];
  endfunction

  task automatic check_outputs();
    chk("in_ready",   32'(in_ready),   32'(!pending));
    chk("out_valid",  32'(out_valid),  32'(pending));
    chk("o",          32'(o),          32'(exp0));
    chk("in_ready4",  32'(in_ready4),  32'(!pending));
    chk("out_valid4", 32'(out_valid4), 32'(pending));
    chk("o4",         32'(o4),         32'(exp4));
    if (out_valid && !prev_ov) rise_cyc.push_back(cyc);
    prev_ov = out_valid;
  endtask

  // One clock: check before the edge, update the model at the edge,
  // then return 1 time unit after it so the caller can drive new inputs.
  task automatic cycle(output bit accepted);
    longint s;
    if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
    else out_ready = (rdy_mode == 1);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    accepted = in_valid && !pending;
    if (accepted) begin
      prods.push_back(longint'(x) * longint'(w));
      if (prods.size() == K) begin
        s = 0;
        foreach (prods[i]) s += prods[i];
        exp0 = sat8(s);
        exp4 = sat8(s >>> 4);
        pending = 1;
        prods.delete();
        nsum++;
        $display("sum %0d: raw=%0d o=%02h o_frac4=%02h", nsum, s, exp0, exp4);
      end
    end else if (pending && out_ready) begin
      pending = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(a);
  endtask

  task automatic send(input logic signed [7:0] xv, input logic signed [7:0] wv, input bit gaps);
    bit a;
    a = 0;
    for (int t = 0; t < 200; t++) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      x = xv;
      w = wv;
      cycle(a);
      if (a) break;
    end
    if (!a) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input int xs[4], input int ws[4], input bit gaps);
    for (int i = 0; i < 4; i++) send(8'(xs[i]), 8'(ws[i]), gaps);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_o"},         32'(o),         32'd0);
    chk({tag, "_o4"},        32'(o4),        32'd0);
    prods.delete();
    pending = 0;
    exp0 = '0;
    exp4 = '0;
    prev_ov = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;

    do_reset("reset");

    // Basic sum 1*5+2*6+3*7+4*8 = 70
    rdy_mode = 1;
    send_vec('{1, 2, 3, 4}, '{5, 6, 7, 8}, 0);
    chk("basic_out_valid", 32'(out_valid), 32'd1);
    chk("basic_in_ready",  32'(in_ready),  32'd0);
    chk("basic_o",         32'(o),         32'h46);
    idle(1);
    chk("basic_one_cycle", 32'(out_valid), 32'd0);

    // Saturation
    send_vec('{127, 127, 127, 127}, '{127, 127, 127, 127}, 0);
    chk("sat_pos", 32'(o), 32'h7F);
    chk("sat_pos4", 32'(o4), 32'h7F);
    send_vec('{-128, -128, -128, -128}, '{127, 127, 127, 127}, 0);
    chk("sat_neg", 32'(o), 32'h80);
    chk("sat_neg4", 32'(o4), 32'h80);

    // Mixed sign: 12; shifted by 4 -> 0
    send_vec('{-3, 10, 0, -1}, '{5, 2, 4, -7}, 0);
    chk("mixed", 32'(o), 32'h0C);
    chk("mixed4", 32'(o4), 32'h00);

    // -15 >>> 4 = -1 (toward minus infinity)
    send_vec('{-3, 0, 0, 0}, '{5, 0, 0, 0}, 0);
    chk("frac_o0", 32'(o), 32'hF1);
    chk("frac_o4", 32'(o4), 32'hFF);

    // Handshake stress with gaps, then backpressure
    rdy_mode = 2;
    send_vec('{1, 2, 3, 4}, '{5, 6, 7, 8}, 1);
    chk("stress_o", 32'(o), 32'h46);
    rdy_mode = 0;
    in_valid = 1'b1;
    x = 8'sd9;
    w = 8'sd9;
    for (int i = 0; i < 3; i++) begin
      cycle(a);
      chk("bp_o", 32'(o), 32'h46);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    send_vec('{1, 1, 1, 1}, '{1, 1, 1, 1}, 1);
    chk("after_bp", 32'(o), 32'h04);

    // Reset mid-accumulation
    idle(1);
    send(8'sd50, 8'sd50, 0);
    send(8'sd50, 8'sd50, 0);
    do_reset("rst_mid");
    send_vec('{1, 1, 1, 1}, '{1, 1, 1, 1}, 0);
    chk("after_rst_mid", 32'(o), 32'h04);

    // Reset during OUT
    idle(1);
    rdy_mode = 0;
    send_vec('{2, 2, 2, 2}, '{2, 2, 2, 2}, 0);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    do_reset("rst_out");

    // Back-to-back with out_ready tied high
    rdy_mode = 1;
    rise_cyc.delete();
    send_vec('{2, 2, 2, 2}, '{3, 3, 3, 3}, 0);
    chk("b2b_first", 32'(o), 32'h18);
    send_vec('{-1, -1, -1, -1}, '{1, 1, 1, 1}, 0);
    chk("b2b_second", 32'(o), 32'hFC);
    idle(1);
    if (rise_cyc.size() == 2) chk("b2b_period", 32'(rise_cyc[1] - rise_cyc[0]), 32'(K + 1));
    else chk("b2b_rises", 32'(rise_cyc.size()), 32'd2);

    // Randomized sums with random gaps and random backpressure
    rdy_mode = 2;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < K; i++) send(8'($urandom), 8'($urandom), 1);
    end
    rdy_mode = 1;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_acc_nbit.md
# neuron_acc_nbit

Sequential signed multiply-accumulate stage that computes one neuron pre-activation sum, Σ x·w over K input/weight pairs. It sits directly upstream of the N-bit ReLU and drives its `s_input` operand. Pairs arrive one per accepted beat on a valid/ready stream. The block accumulates at full precision, applies an arithmetic fixed-point shift, saturates to N bits, and holds the result on a valid/ready output until it is consumed.

## Interface
Parameters:
- `N`, 8: operand and result width, two's-complement signed.
- `K`, 4: number of (x, w) pairs per sum; K ≥ 1.
- `FRAC`, 0: arithmetic right shift applied to the sum before saturation; 0 ≤ FRAC < 2N.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  an (x, w) pair is presented.
- `in_ready`  out  1  block accepts a pair this cycle.
- `x`  in  N signed  activation operand.
- `w`  in  N signed  weight operand.
- `out_valid`  out  1  `o` holds a completed sum.
- `out_ready`  in  1  downstream consumes `o`.
- `o`  out  N signed  saturated, shifted sum; feeds the ReLU `s_input`.

## Operation
- Internal accumulator `acc` is ACCW = 2N + clog2(K) bits wide, signed. The product x·w is 2N bits, sign-extended into `acc`. No overflow is possible inside `acc`.
- `cnt` counts accepted beats, 0..K-1.
- State machine, two states:
  - ACCUM: `in_ready`=1, `out_valid`=0.
    - On an accepted beat (`in_valid` & `in_ready`) with `cnt` < K-1: `acc` += x·w and `cnt` += 1.
    - On an accepted beat with `cnt` == K-1: compute `s` = `acc` + x·w.
    - Register `o` = sat((`s` >>> FRAC)). Clear `acc` and `cnt`. Go to OUT.
  - OUT: `in_ready`=0, `out_valid`=1, `o` held stable.
    - When `out_ready`=1: go to ACCUM.
    - `o` keeps its last value; it is not cleared.
- Shift: arithmetic, truncating toward −∞. No rounding.
- Saturation: values > 2^(N-1)−1 become 2^(N-1)−1. Values < −2^(N-1) become −2^(N-1).
- `in_valid` without `in_ready` (state OUT): the pair is ignored. `x` and `w` are don't-care.
- `in_valid` may deassert between beats. Gaps of any length do not affect the sum.
- `in_ready` is a function of state only, plus forced 0 while `rst`=1. It never depends on `in_valid`. `out_valid` is a function of state only.

## Timing
- Reset values, applied immediately on `rst` assertion:
  - state=ACCUM, `acc`=0, `cnt`=0.
  - `out_valid`=0, `o`=0.
  - `in_ready`=0 while `rst` is high, 1 from the first cycle after deassertion.
- Latency: `out_valid` rises the cycle after the K-th accepted beat.
- Back-to-back throughput:
  - If `out_ready`=1 when `out_valid` rises, OUT lasts one cycle.
  - `in_ready` returns the following cycle.
  - Minimum period: K+1 cycles per result.
- Backpressure: `out_ready`=0 holds OUT indefinitely. `o` and `out_valid` stay stable, and no inputs are accepted.
- Reset mid-accumulation discards the partial sum and `cnt`. The next K accepted beats form a fresh sum.
- Reset during OUT drops the pending result; `out_valid`=0 immediately.
- K=1: every accepted beat goes straight to OUT.

## Test plan
- N=8, K=4, FRAC=0; x={1,2,3,4}, w={5,6,7,8} streamed with `out_ready`=1 → after 4th beat, `out_valid`=1 for one cycle, `o`=70 (0x46); `in_ready` low exactly that cycle.
- Positive saturation: x=127, w=127 for all 4 beats (sum 64516) → `o`=0x7F. Negative saturation: x=−128, w=127 ×4 (sum −65024) → `o`=0x80.
- Mixed-sign exact: x={−3,10,0,−1}, w={5,2,4,−7} (sum 12) → `o`=0x0C. Repeat with FRAC=4 on x={−3,0,0,0}, w={5,0,0,0} (−15>>>4) → `o`=0xFF (−1).
- Handshake stress, with `in_valid` toggling randomly and gaps:
  - x={1,2,3,4}, w={5,6,7,8} → `o`=70.
  - Then hold `out_ready`=0 for 3 cycles while driving `in_valid`=1, x=9, w=9 → `o` stays 0x46, `in_ready`=0, and no beat is counted.
  - Release → the next sum of x=1, w=1 ×4 is exactly 4.
- Reset mid-operation:
  - Accept 2 beats of x=50, w=50, then pulse `rst` → `out_valid`=0, `o`=0.
  - Then 4 beats x=1, w=1 → `o`=4.
  - Pulse `rst` during OUT → `out_valid` drops immediately.
- Back-to-back: two sums with `out_ready` tied 1 (4×(2·3)=24, then 4×(−1·1)=−4) → `o`=0x18 then 0xFC, results 5 cycles apart.
